div16x8: RTL

Iterative unsigned divider, the inverse of the 8x8 array multiplier: it divides a 16-bit dividend (a multiplier product) by an 8-bit divisor and returns an 8-bit quotient and an 8-bit remainder. It uses a restoring shift-subtract loop and produces one quotient bit per clock. It sits beside mult8x8 in the arithmetic datapath, where it recovers an operand from a product, and it is exercised against mult8x8 in round-trip tests.

---
 rtl/div16x8_if.sv | 25 ++
 rtl/div16x8.sv | 116 +++++++++++
 2 files changed

// File: rtl/div16x8_if.sv
// div16x8_if: request/result bundle for the 16/8 unsigned divider.
//   master (requester): drives start, dividend, divisor; observes results.
//   slave  (divider)  : observes request; drives busy, done, quotient,
//                       remainder, div_by_zero, overflow.
interface div16x8_if;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;
    logic        overflow;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/div16x8.sv
// div16x8: iterative restoring unsigned divider, 16-bit dividend by 8-bit
// divisor, one quotient bit per clock (8 CALC cycles, done in cycle 9).
// Divide-by-zero and quotient overflow finish immediately (done in cycle 1)
// with saturated 8'hFF results.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - div16x8_if.slave: start/dividend/divisor in;
//          busy/done/quotient/remainder/div_by_zero/overflow out
module div16x8 (
    input  logic      clk,
    input  logic      rst,
    div16x8_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state_q;
    logic [8:0]  rem_q;
    logic [7:0]  quo_q;
    logic [2:0]  cnt_q;
    logic [7:0]  divisor_q;
    logic        busy_q;
    logic        done_q;
    logic [7:0]  quotient_q;
    logic [7:0]  remainder_q;
    logic        dbz_q;
    logic        ovf_q;

    logic [9:0]  shift_d;
    logic [9:0]  trial_d;
    logic [8:0]  rem_d;
    logic [7:0]  quo_d;

    // One restoring step: shift {R,Q} left, trial-subtract the divisor and
    // keep the difference only when it did not borrow (trial_d[9] clear).
    always_comb begin
        shift_d = {rem_q, quo_q[7]};
        trial_d = shift_d - {2'b00, divisor_q};
        rem_d   = trial_d[9] ? shift_d[8:0] : trial_d[8:0];
        quo_d   = {quo_q[6:0], ~trial_d[9]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            divisor_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        divisor_q <= bus.divisor;
                        if (bus.divisor == '0) begin
                            state_q     <= DONE;
                            done_q      <= 1'b1;
                            dbz_q       <= 1'b1;
                            ovf_q       <= 1'b0;
                            quotient_q  <= '1;
                            remainder_q <= '1;
                        end else if (bus.dividend[15:8] >= bus.divisor) begin
                            state_q     <= DONE;
                            done_q      <= 1'b1;
                            dbz_q       <= 1'b0;
                            ovf_q       <= 1'b1;
                            quotient_q  <= '1;
                            remainder_q <= '1;
                        end else begin
                            // Visible results and flags keep their previous
                            // values until this division completes.
                            state_q <= CALC;
                            busy_q  <= 1'b1;
                            rem_q   <= {1'b0, bus.dividend[15:8]};
                            quo_q   <= bus.dividend[7:0];
                            cnt_q   <= '0;
                        end
                    end else if (state_q == DONE) begin
                        state_q <= IDLE;
                    end
                end
                CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        quotient_q  <= quo_d;
                        remainder_q <= rem_d[7:0];
                        dbz_q       <= 1'b0;
                        ovf_q       <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.overflow    = ovf_q;

endmodule
